// File: rtl/spi_req_scheduler.sv
// rtl/spi_req_scheduler.sv - round-robin scheduler sharing one spi_master among NUM_REQ requesters
// Define SPI_SCHED_TIMEOUT_EN to add the WAIT watchdog and the timeout_err output.
module spi_req_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int IDX_WIDTH  = 2,
  parameter int DATA_WIDTH = 16,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [NUM_REQ-1:0]            cs_n,
  output logic                          busy,
  output logic                          spi_start,
  output logic [DATA_WIDTH-1:0]         spi_data_in,
  input  logic                          spi_busy,
  input  logic                          spi_new_data,
  input  logic [DATA_WIDTH-1:0]         spi_data_out
`ifdef SPI_SCHED_TIMEOUT_EN
  ,
  output logic                          timeout_err
`endif
);

  localparam int CNT_MAX0 = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_MAX  = (CNT_MAX0 > TIMEOUT) ? CNT_MAX0 : TIMEOUT;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT, S_HOLD} state_t;

  state_t                state, state_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic [IDX_WIDTH-1:0]  sel, sel_d;
  logic [IDX_WIDTH-1:0]  rr_ptr, rr_d, rr_next;
  logic [IDX_WIDTH-1:0]  pick;
  logic                  pick_found;
  logic [DATA_WIDTH-1:0] pick_data;
  logic [NUM_REQ-1:0]    gnt_d, rsp_valid_d, cs_n_d;
  logic [DATA_WIDTH-1:0] rsp_data_d, spi_data_d;
  logic                  spi_start_d;
`ifdef SPI_SCHED_TIMEOUT_EN
  logic                  timeout_d;
`endif

  // First requester at or after rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    int cand;
    pick_found = 1'b0;
    pick       = '0;
    cand       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_found && req[IDX_WIDTH'(cand)]) begin
        pick_found = 1'b1;
        pick       = IDX_WIDTH'(cand);
      end
    end
  end

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick == IDX_WIDTH'(i)) pick_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign rr_next = (sel == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : sel + 1'b1;

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    sel_d       = sel;
    rr_d        = rr_ptr;
    cs_n_d      = cs_n;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data;
    spi_start_d = 1'b0;
    spi_data_d  = spi_data_in;
`ifdef SPI_SCHED_TIMEOUT_EN
    timeout_d   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (pick_found && !spi_busy) begin
          sel_d      = pick;
          spi_data_d = pick_data;
          gnt_d      = NUM_REQ'(1) << pick;
          cs_n_d     = ~(NUM_REQ'(1) << pick);
          cnt_d      = '0;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == CNT_W'(CS_SETUP - 1)) begin
          spi_start_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_WAIT;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      S_WAIT: begin
        if (spi_new_data) begin
          rsp_data_d  = spi_data_out;
          rsp_valid_d = NUM_REQ'(1) << sel;
          cnt_d       = '0;
          state_d     = S_HOLD;
        end
`ifdef SPI_SCHED_TIMEOUT_EN
        // Watchdog abort: release the slave and move fairness on without a response.
        else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          cs_n_d    = '1;
          rr_d      = rr_next;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
`endif
      end
      S_HOLD: begin
        if (cnt == CNT_W'(CS_HOLD - 1)) begin
          cs_n_d  = '1;
          rr_d    = rr_next;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      sel         <= '0;
      rr_ptr      <= '0;
      cs_n        <= '1;
      gnt         <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      spi_start   <= 1'b0;
      spi_data_in <= '0;
      busy        <= 1'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      sel         <= sel_d;
      rr_ptr      <= rr_d;
      cs_n        <= cs_n_d;
      gnt         <= gnt_d;
      rsp_valid   <= rsp_valid_d;
      rsp_data    <= rsp_data_d;
      spi_start   <= spi_start_d;
      spi_data_in <= spi_data_d;
      busy        <= (state_d != S_IDLE);
`ifdef SPI_SCHED_TIMEOUT_EN
      timeout_err <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_req_scheduler.sv
// tb/tb_spi_req_scheduler.sv - randomized self-checking bench for spi_req_scheduler
// Define SPI_SCHED_TIMEOUT_EN to also exercise the WAIT watchdog.
module tb_spi_req_scheduler;
  localparam int NUM_REQ    = 4;
  localparam int IDX_WIDTH  = 2;
  localparam int DATA_WIDTH = 16;
  localparam int CS_SETUP   = 2;
  localparam int CS_HOLD    = 2;
  localparam int TIMEOUT    = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_REQ-1:0]            req = '0;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data = '0;
  logic [NUM_REQ-1:0]            gnt, rsp_valid, cs_n;
  logic [DATA_WIDTH-1:0]         rsp_data, spi_data_in;
  logic [DATA_WIDTH-1:0]         spi_data_out = '0;
  logic                          busy, spi_start, spi_busy;
  logic                          spi_new_data = 1'b0;
`ifdef SPI_SCHED_TIMEOUT_EN
  logic                          timeout_err;
`endif

  logic busy_force = 1'b0, slave_busy = 1'b0, slave_mute = 1'b0, fixed_en = 1'b0;
  logic [DATA_WIDTH-1:0] fixed_word = '0;
  logic [DATA_WIDTH-1:0] exp_data [NUM_REQ];
  int slave_cnt = 0;
  int checks = 0, failures = 0, cyc = 0, f_run = 0, cs_multi = 0;
  int g_idx[$], g_gap[$], r_idx[$];
  logic [DATA_WIDTH-1:0] g_dat[$], r_dat[$], sl_used[$];

  assign spi_busy = busy_force | slave_busy;
  always #5 clk = ~clk;

  spi_req_scheduler #(
    .NUM_REQ(NUM_REQ), .IDX_WIDTH(IDX_WIDTH), .DATA_WIDTH(DATA_WIDTH),
    .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .cs_n(cs_n), .busy(busy),
    .spi_start(spi_start), .spi_data_in(spi_data_in), .spi_busy(spi_busy),
    .spi_new_data(spi_new_data), .spi_data_out(spi_data_out)
`ifdef SPI_SCHED_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  // Behavioural spi_master: answers each start after 1..6 cycles unless muted.
  always @(negedge clk) begin
    spi_new_data = 1'b0;
    if (rst) begin
      slave_cnt  = 0;
      slave_busy = 1'b0;
    end else begin
      if (slave_cnt > 0) begin
        slave_cnt--;
        if (slave_cnt == 0) begin
          spi_data_out = fixed_en ? fixed_word : DATA_WIDTH'($urandom);
          sl_used.push_back(spi_data_out);
          spi_new_data = 1'b1;
          slave_busy   = 1'b0;
        end
      end
      if (spi_start && !slave_mute) begin
        slave_cnt  = $urandom_range(1, 6);
        slave_busy = 1'b1;
      end
    end
  end

  // Event log of grants and responses, plus idle-gap and chip-select exclusivity tracking.
  always @(negedge clk) begin
    cyc++;
    if (!$onehot0(~cs_n)) cs_multi++;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        g_idx.push_back(i); g_dat.push_back(spi_data_in); g_gap.push_back(f_run);
      end
      if (rsp_valid[i]) begin
        r_idx.push_back(i); r_dat.push_back(rsp_data);
      end
    end
    f_run = (cs_n == '1) ? f_run + 1 : 0;
  end

  function automatic int model_pick(input logic [NUM_REQ-1:0] mask, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (mask[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    g_idx.delete(); g_gap.delete(); g_dat.delete();
    r_idx.delete(); r_dat.delete(); sl_used.delete();
  endtask

  task automatic set_data(input int i, input logic [DATA_WIDTH-1:0] w);
    req_data[i*DATA_WIDTH +: DATA_WIDTH] = w;
    exp_data[i] = w;
  endtask

  task automatic apply_reset();
    req = '0; busy_force = 1'b0; slave_mute = 1'b0; fixed_en = 1'b0;
    rst = 1'b1; step(2); rst = 1'b0;
    clear_logs();
  endtask

  task automatic drain(output bit ok);
    int n = 0;
    while ((busy || r_idx.size() < g_idx.size()) && n < 200) begin step(1); n++; end
    ok = (n < 200);
  endtask

  task automatic test_reset();
    rst = 1'b1; step(2);
    checks++; if (cs_n !== 4'hF) begin failures++; $display("FAIL reset_cs_n got=%b exp=1111", cs_n); end
    checks++; if ({gnt, rsp_valid, spi_start, busy} !== '0) begin failures++;
      $display("FAIL reset_pulses got=%b exp=0", {gnt, rsp_valid, spi_start, busy}); end
    checks++; if (rsp_data !== '0 || spi_data_in !== '0) begin failures++;
      $display("FAIL reset_data got=%h/%h exp=0/0", rsp_data, spi_data_in); end
    rst = 1'b0; step(1); clear_logs();
  endtask

  task automatic test_single();
    int c0, n; bit ok;
    apply_reset();
    fixed_en = 1'b1; fixed_word = 16'hF0F0;
    set_data(2, 16'hA5C3);
    req = 4'b0100; c0 = cyc;
    step(1);
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
    checks++; if (cs_n !== 4'b1011) begin failures++; $display("FAIL single_cs got=%b exp=1011", cs_n); end
    checks++; if (spi_data_in !== 16'hA5C3) begin failures++; $display("FAIL single_txdata got=%h exp=a5c3", spi_data_in); end
    req = '0;
    step(1);
    checks++; if (gnt !== '0) begin failures++; $display("FAIL single_gnt_pulse got=%b exp=0000", gnt); end
    n = 0; while (!spi_start && n < 20) begin step(1); n++; end
    checks++; if (cyc - c0 != CS_SETUP + 1) begin failures++;
      $display("FAIL single_start_latency got=%0d exp=%0d", cyc - c0, CS_SETUP + 1); end
    n = 0; while (rsp_valid === '0 && n < 50) begin step(1); n++; end
    checks++; if (rsp_valid !== 4'b0100 || rsp_data !== 16'hF0F0) begin failures++;
      $display("FAIL single_rsp got=%b/%h exp=0100/f0f0", rsp_valid, rsp_data); end
    checks++; if (spi_data_in !== 16'hA5C3) begin failures++; $display("FAIL single_txstable got=%h exp=a5c3", spi_data_in); end
    step(CS_HOLD - 1);
    checks++; if (cs_n !== 4'b1011 || rsp_valid !== '0) begin failures++;
      $display("FAIL single_hold got=%b/%b exp=1011/0000", cs_n, rsp_valid); end
    step(1);
    checks++; if (cs_n !== 4'hF || busy !== 1'b0) begin failures++;
      $display("FAIL single_release got=%b/%b exp=1111/0", cs_n, busy); end
    drain(ok);
    fixed_en = 1'b0;
  endtask

  task automatic test_round_robin();
    int n, ptr, exp; bit ok;
    apply_reset(); ptr = 0;
    for (int i = 0; i < NUM_REQ; i++) set_data(i, DATA_WIDTH'($urandom));
    req = '1; n = 0;
    while (g_idx.size() < 5 && n < 400) begin step(1); n++; end
    req = '0;
    drain(ok);
    checks++; if (g_idx.size() != 5 || !ok) begin failures++; $display("FAIL rr_count got=%0d exp=5", g_idx.size()); end
    for (int k = 0; k < g_idx.size() && k < 5; k++) begin
      exp = model_pick('1, ptr);
      checks++; if (g_idx[k] != exp) begin failures++; $display("FAIL rr_order k=%0d got=%0d exp=%0d", k, g_idx[k], exp); end
      checks++; if (g_dat[k] !== exp_data[exp]) begin failures++; $display("FAIL rr_txdata k=%0d got=%h exp=%h", k, g_dat[k], exp_data[exp]); end
      if (k > 0) begin
        checks++; if (g_gap[k] != 1) begin failures++; $display("FAIL rr_idle_gap k=%0d got=%0d exp=1", k, g_gap[k]); end
      end
      checks++; if (k >= r_idx.size() || k >= sl_used.size() || r_idx[k] != exp || r_dat[k] !== sl_used[k]) begin
        failures++; $display("FAIL rr_rsp k=%0d got_n=%0d exp_idx=%0d", k, r_idx.size(), exp); end
      ptr = (exp + 1) % NUM_REQ;
    end
  endtask

  task automatic test_rr_skip();
    int n, handled, ptr, exp; bit ok; logic [NUM_REQ-1:0] pending;
    apply_reset();
    set_data(1, DATA_WIDTH'($urandom));
    req = 4'b0010; n = 0;
    while (g_idx.size() < 1 && n < 20) begin step(1); n++; end
    req = '0;
    drain(ok);
    ptr = 2; clear_logs();
    set_data(3, DATA_WIDTH'($urandom));
    pending = 4'b1010; req = pending; n = 0; handled = 0;
    while (handled < 2 && n < 300) begin
      step(1); n++;
      while (handled < g_idx.size()) begin
        exp = model_pick(pending, ptr);
        checks++; if (g_idx[handled] != exp) begin failures++;
          $display("FAIL skip_order k=%0d got=%0d exp=%0d", handled, g_idx[handled], exp); end
        req[g_idx[handled]] = 1'b0;
        if (exp >= 0) begin pending[exp] = 1'b0; ptr = (exp + 1) % NUM_REQ; end
        handled++;
      end
    end
    drain(ok);
    checks++; if (handled != 2 || !ok) begin failures++; $display("FAIL skip_count got=%0d exp=2", handled); end
  endtask

  task automatic test_spi_busy();
    bit ok;
    apply_reset();
    set_data(0, DATA_WIDTH'($urandom));
    busy_force = 1'b1; req = 4'b0001;
    step(6);
    checks++; if (g_idx.size() != 0 || cs_n !== 4'hF || busy !== 1'b0) begin failures++;
      $display("FAIL busy_block got_gnts=%0d cs=%b busy=%b exp=0/1111/0", g_idx.size(), cs_n, busy); end
    busy_force = 1'b0;
    step(1);
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL busy_release_gnt got=%b exp=0001", gnt); end
    req = '0;
    drain(ok);
    checks++; if (!ok || r_idx.size() != 1) begin failures++; $display("FAIL busy_complete got=%0d exp=1", r_idx.size()); end
  endtask

  task automatic test_reset_mid();
    int n; bit ok; logic [DATA_WIDTH-1:0] w;
    apply_reset();
    slave_mute = 1'b1;
    set_data(0, DATA_WIDTH'($urandom)); req = 4'b0001; n = 0;
    while (!spi_start && n < 20) begin step(1); n++; if (gnt !== '0) req = '0; end
    step(3);
    checks++; if (busy !== 1'b1 || cs_n !== 4'b1110) begin failures++;
      $display("FAIL midrst_wait got=%b/%b exp=1/1110", busy, cs_n); end
    rst = 1'b1; step(1);
    checks++; if (cs_n !== 4'hF || busy !== 1'b0 || rsp_valid !== '0) begin failures++;
      $display("FAIL midrst_state got=%b/%b/%b exp=1111/0/0000", cs_n, busy, rsp_valid); end
    rst = 1'b0; slave_mute = 1'b0; step(1);
    checks++; if (r_idx.size() != 0) begin failures++; $display("FAIL midrst_norsp got=%0d exp=0", r_idx.size()); end
    clear_logs();
    w = DATA_WIDTH'($urandom); set_data(0, w); req = 4'b0001;
    step(1);
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL midrst_regnt got=%b exp=0001", gnt); end
    req = '0;
    drain(ok);
    checks++; if (!ok || r_idx.size() != 1 || sl_used.size() != 1 || r_idx[0] != 0 || r_dat[0] !== sl_used[0] || g_dat[0] !== w) begin
      failures++; $display("FAIL midrst_complete got_n=%0d exp=1", r_idx.size()); end
  endtask

  task automatic test_random();
    int handled, ptr, exp; bit ok; logic [NUM_REQ-1:0] pending, add;
    apply_reset();
    ptr = 0; handled = 0; pending = '0; cs_multi = 0;
    for (int t = 0; t < 600; t++) begin
      step(1);
      while (handled < g_idx.size()) begin
        exp = model_pick(pending, ptr);
        checks++; if (g_idx[handled] != exp) begin failures++;
          $display("FAIL rand_order k=%0d got=%0d exp=%0d", handled, g_idx[handled], exp); end
        checks++; if (exp >= 0 && g_dat[handled] !== exp_data[exp]) begin failures++;
          $display("FAIL rand_txdata k=%0d got=%h exp=%h", handled, g_dat[handled], exp_data[exp]); end
        req[g_idx[handled]] = 1'b0;
        if (exp >= 0) begin pending[exp] = 1'b0; ptr = (exp + 1) % NUM_REQ; end
        handled++;
      end
      if (t < 480 && $urandom_range(0, 3) == 0) begin
        add = NUM_REQ'($urandom) & ~pending;
        for (int i = 0; i < NUM_REQ; i++)
          if (add[i]) begin set_data(i, DATA_WIDTH'($urandom)); req[i] = 1'b1; end
        pending = pending | add;
      end
    end
    drain(ok);
    checks++; if (!ok || pending !== '0 || r_idx.size() != g_idx.size()) begin failures++;
      $display("FAIL rand_drain pending=%b rsp=%0d gnt=%0d", pending, r_idx.size(), g_idx.size()); end
    for (int k = 0; k < r_idx.size() && k < sl_used.size() && k < g_idx.size(); k++) begin
      checks++; if (r_idx[k] != g_idx[k] || r_dat[k] !== sl_used[k]) begin failures++;
        $display("FAIL rand_rsp k=%0d got=%0d/%h exp=%0d/%h", k, r_idx[k], r_dat[k], g_idx[k], sl_used[k]); end
    end
    checks++; if (cs_multi != 0) begin failures++; $display("FAIL cs_exclusive got=%0d exp=0", cs_multi); end
  endtask

`ifdef SPI_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int n, s, seen; bit ok; logic [DATA_WIDTH-1:0] old;
    apply_reset();
    set_data(3, DATA_WIDTH'($urandom)); req = 4'b1000; n = 0;
    while (g_idx.size() < 1 && n < 20) begin step(1); n++; end
    req = '0;
    drain(ok);
    old = rsp_data;
    clear_logs(); slave_mute = 1'b1;
    set_data(1, DATA_WIDTH'($urandom)); req = 4'b0010; n = 0;
    while (!spi_start && n < 20) begin step(1); n++; if (gnt !== '0) req = '0; end
    s = cyc; n = 0; seen = 0;
    while (!timeout_err && n < 200) begin step(1); n++; end
    checks++; if (cyc - s != TIMEOUT) begin failures++; $display("FAIL tmo_latency got=%0d exp=%0d", cyc - s, TIMEOUT); end
    checks++; if (cs_n !== 4'hF || rsp_data !== old || r_idx.size() != 0) begin failures++;
      $display("FAIL tmo_state got=%b/%h/%0d exp=1111/%h/0", cs_n, rsp_data, r_idx.size(), old); end
    step(1);
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL tmo_pulse got=%b exp=0", timeout_err); end
    slave_mute = 1'b0; clear_logs();
    set_data(0, DATA_WIDTH'($urandom)); req = 4'b0011; n = 0;
    while (g_idx.size() < 1 && n < 20) begin step(1); n++; end
    req = '0;
    checks++; if (g_idx.size() < 1 || g_idx[0] != model_pick(4'b0011, 2)) begin failures++;
      $display("FAIL tmo_rr_advance got_n=%0d exp_idx=%0d", g_idx.size(), model_pick(4'b0011, 2)); end
    drain(ok);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_rr_skip();
    test_spi_busy();
    test_reset_mid();
    test_random();
`ifdef SPI_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
